// File: rtl/rv_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_writeback_pkg : load funct3 codes and writeback FSM state type    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv_writeback_pkg;

   localparam logic [2:0] LDST_B  = 3'b000;
   localparam logic [2:0] LDST_H  = 3'b001;
   localparam logic [2:0] LDST_L  = 3'b010;
   localparam logic [2:0] LDST_BU = 3'b100;
   localparam logic [2:0] LDST_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LOAD = 2'd1,
      ST_HELD      = 2'd2
   } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/rv_writeback_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_writeback_load_align : byte/half/word select and extension        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_writeback_load_align
   import rv_writeback_pkg::*;
(
   input  logic [31:0] i_data,
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_fun,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_data[7:0];
      case (i_addr)
         2'd0:    w_byte = i_data[7:0];
         2'd1:    w_byte = i_data[15:8];
         2'd2:    w_byte = i_data[23:16];
         default: w_byte = i_data[31:24];
      endcase
      w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];
   end

   // Reserved funct3 codes fall through to the raw word.
   always_comb begin
      o_result = i_data;
      case (i_fun)
         LDST_B:  o_result = {{24{w_byte[7]}}, w_byte};
         LDST_BU: o_result = {24'h0, w_byte};
         LDST_H:  o_result = {{16{w_half[15]}}, w_half};
         LDST_HU: o_result = {16'h0, w_half};
         LDST_L:  o_result = i_data;
         default: o_result = i_data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_writeback : load completion, stall and single-commit RF write     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv_writeback
   import rv_writeback_pkg::*;
#(
   parameter int g_load_timeout = 255
)(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        x_stall_i,
   input  logic [4:0]  w_rd_i,
   input  logic [31:0] w_rd_value_i,
   input  logic        w_rd_write_i,
   input  logic        w_load_i,
   input  logic [2:0]  w_fun_i,
   input  logic [31:0] w_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   output logic        w_stall_req_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o,
   output logic        w_load_error_o
);

   localparam int c_cnt_w_raw = $clog2(g_load_timeout + 1);
   localparam int c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;
   localparam logic [c_cnt_w-1:0] c_tmo_last =
      c_cnt_w'((g_load_timeout == 0) ? 0 : g_load_timeout - 1);

   wb_state_t          r_state;
   wb_state_t          w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [4:0]         r_rf_rd;
   logic [31:0]        r_rf_value;
   logic               r_rf_write;
   logic               r_load_error;

   logic [31:0]        w_aligned;
   logic               w_timeout;
   logic               w_commit;
   logic [31:0]        w_commit_val;
   logic               w_err_set;
   logic               w_cnt_clr;
   logic               w_cnt_inc;
   logic               w_stall_req;
   logic               w_unused_addr;

   assign w_unused_addr = ^w_dm_addr_i[31:2];

   rv_writeback_load_align u_align (
      .i_data   (dm_data_l_i),
      .i_addr   (w_dm_addr_i[1:0]),
      .i_fun    (w_fun_i),
      .o_result (w_aligned)
   );

   assign w_timeout = (g_load_timeout != 0) && (r_cnt == c_tmo_last) && !dm_load_done_i;

   always_comb begin
      w_state_nxt  = r_state;
      w_commit     = 1'b0;
      w_commit_val = w_rd_value_i;
      w_err_set    = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_stall_req  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_load_i && !dm_load_done_i) begin
               w_stall_req = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_WAIT_LOAD;
            end else begin
               w_commit     = w_rd_write_i;
               w_commit_val = w_load_i ? w_aligned : w_rd_value_i;
               w_state_nxt  = x_stall_i ? ST_HELD : ST_IDLE;
            end
         end
         ST_WAIT_LOAD: begin
            w_cnt_inc = 1'b1;
            if (dm_load_done_i) begin
               w_commit     = w_rd_write_i;
               w_commit_val = w_aligned;
               w_state_nxt  = x_stall_i ? ST_HELD : ST_IDLE;
            end else if (w_timeout) begin
               w_commit     = w_rd_write_i;
               w_commit_val = 32'h0;
               w_err_set    = 1'b1;
               w_state_nxt  = x_stall_i ? ST_HELD : ST_IDLE;
            end else begin
               w_stall_req = 1'b1;
            end
         end
         ST_HELD: begin
            // Instruction already committed; wait for upstream to advance.
            if (!x_stall_i)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_rf_rd      <= 5'd0;
         r_rf_value   <= 32'h0;
         r_rf_write   <= 1'b0;
         r_load_error <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rf_write <= w_commit;
         if (w_commit) begin
            r_rf_rd    <= w_rd_i;
            r_rf_value <= w_commit_val;
         end
         if (w_cnt_clr)
            r_cnt <= '0;
         else if (w_cnt_inc)
            r_cnt <= r_cnt + c_cnt_w'(1);
         if (w_err_set)
            r_load_error <= 1'b1;
      end
   end

   assign w_stall_req_o  = w_stall_req;
   assign rf_rd_o        = r_rf_rd;
   assign rf_rd_value_o  = r_rf_value;
   assign rf_rd_write_o  = r_rf_write;
   assign w_load_error_o = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_rv_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rv_writeback : scoreboard bench with transaction-level reference  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rv_writeback;

   localparam int c_tmo = 4;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        x_stall_i;
   logic [4:0]  w_rd_i;
   logic [31:0] w_rd_value_i;
   logic        w_rd_write_i;
   logic        w_load_i;
   logic [2:0]  w_fun_i;
   logic [31:0] w_dm_addr_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        w_stall_req_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_write_o;
   logic        w_load_error_o;

   rv_writeback #(.g_load_timeout(c_tmo)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .x_stall_i      (x_stall_i),
      .w_rd_i         (w_rd_i),
      .w_rd_value_i   (w_rd_value_i),
      .w_rd_write_i   (w_rd_write_i),
      .w_load_i       (w_load_i),
      .w_fun_i        (w_fun_i),
      .w_dm_addr_i    (w_dm_addr_i),
      .dm_data_l_i    (dm_data_l_i),
      .dm_load_done_i (dm_load_done_i),
      .w_stall_req_o  (w_stall_req_o),
      .rf_rd_o        (rf_rd_o),
      .rf_rd_value_o  (rf_rd_value_o),
      .rf_rd_write_o  (rf_rd_write_o),
      .w_load_error_o (w_load_error_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] val;
   } exp_t;

   exp_t q_exp[$];
   int   n_total = 0;
   int   n_bad   = 0;
   logic err_exp = 1'b0;

   function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] d);
      int unsigned b;
      int unsigned h;
      b = (d >> (8 * int'(a[1:0]))) & 32'hFF;
      h = (d >> (16 * int'(a[1]))) & 32'hFFFF;
      case (f)
         3'b000:  return (b >= 128) ? (32'(b) - 32'd256) : 32'(b);
         3'b100:  return 32'(b);
         3'b001:  return (h >= 32768) ? (32'(h) - 32'd65536) : 32'(h);
         3'b101:  return 32'(h);
         default: return d;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: every RF write must match the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_n_i === 1'b1) begin
            check("load_error", {31'h0, w_load_error_o}, {31'h0, err_exp});
            if (rf_rd_write_o === 1'b1) begin
               if (q_exp.size() == 0) begin
                  check("spurious_write", 32'h1, 32'h0);
               end else begin
                  e = q_exp.pop_front();
                  check("rf_rd", {27'h0, rf_rd_o}, {27'h0, e.rd});
                  check("rf_value", rf_rd_value_o, e.val);
               end
            end
         end
      end
   end

   // wt: cycle (from arrival) at which done pulses; <0 or >c_tmo means timeout.
   // xs: x_stall_i held for the first xs cycles of the instruction.
   task automatic issue(input logic [4:0] rd, input logic [31:0] val, input logic wr,
                        input logic ld, input logic [2:0] fun, input logic [31:0] addr,
                        input logic [31:0] data, input int wt, input int xs);
      int   cyc;
      int   res;
      logic tmo;
      logic acc;
      exp_t e;
      tmo = ld && (wt < 0 || wt > c_tmo);
      res = !ld ? 0 : (tmo ? c_tmo : wt);
      if (wr) begin
         e.rd  = rd;
         e.val = !ld ? val : (tmo ? 32'h0 : ref_load(fun, addr, data));
         q_exp.push_back(e);
      end
      cyc = 0;
      acc = 1'b0;
      while (!acc) begin
         @(negedge clk_i);
         w_rd_i       = rd;
         w_rd_value_i = val;
         w_rd_write_i = wr;
         w_load_i     = ld;
         w_fun_i      = fun;
         w_dm_addr_i  = addr;
         x_stall_i    = (cyc < xs);
         if (ld && !tmo && cyc == wt) begin
            dm_load_done_i = 1'b1;
            dm_data_l_i    = data;
         end else begin
            dm_load_done_i = (!ld || cyc > res) && ($urandom_range(0, 3) == 0);
            dm_data_l_i    = $urandom;
         end
         #2;
         check("stall_req", {31'h0, w_stall_req_o}, {31'h0, (ld && cyc < res)});
         acc = (cyc >= res) && !x_stall_i;
         @(posedge clk_i);
         if (tmo && cyc == res)
            err_exp = 1'b1;
         cyc++;
         if (cyc > 100) begin
            check("issue_budget", 32'h1, 32'h0);
            acc = 1'b1;
         end
      end
   endtask

   task automatic idle_inputs();
      x_stall_i      = 1'b0;
      w_rd_i         = 5'd0;
      w_rd_value_i   = 32'h0;
      w_rd_write_i   = 1'b0;
      w_load_i       = 1'b0;
      w_fun_i        = 3'b000;
      w_dm_addr_i    = 32'h0;
      dm_data_l_i    = 32'h0;
      dm_load_done_i = 1'b0;
   endtask

   initial begin
      int wt;
      int xs;
      rst_n_i = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk_i);
      check("rst_write", {31'h0, rf_rd_write_o}, 32'h0);
      check("rst_rd", {27'h0, rf_rd_o}, 32'h0);
      check("rst_value", rf_rd_value_o, 32'h0);
      check("rst_err", {31'h0, w_load_error_o}, 32'h0);
      check("rst_stall", {31'h0, w_stall_req_o}, 32'h0);
      rst_n_i = 1'b1;

      issue(5'd5, 32'h1234, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);
      issue(5'd7, 32'h0, 1'b1, 1'b1, 3'b000, 32'h1003, 32'h8000_0000, 3, 0);
      issue(5'd8, 32'h0, 1'b1, 1'b1, 3'b100, 32'h1003, 32'h8000_0000, 3, 0);
      issue(5'd9, 32'h0, 1'b1, 1'b1, 3'b001, 32'h2002, 32'h7FFF_0000, 0, 0);
      issue(5'd10, 32'h0, 1'b1, 1'b1, 3'b101, 32'h2003, 32'h8001_1234, 1, 0);
      issue(5'd11, 32'h0, 1'b1, 1'b1, 3'b010, 32'h2001, 32'hDEAD_BEEF, 2, 0);
      issue(5'd12, 32'hCAFE_F00D, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 0, 4);
      issue(5'd13, 32'h0, 1'b1, 1'b1, 3'b000, 32'h3001, 32'h0000_FF00, 2, 4);
      issue(5'd14, 32'h0, 1'b1, 1'b1, 3'b010, 32'h3000, 32'h1357_9BDF, c_tmo, 0);
      issue(5'd15, 32'h0, 1'b0, 1'b1, 3'b010, 32'h3000, 32'h1111_2222, 1, 0);
      issue(5'd16, 32'h5555, 1'b1, 1'b1, 3'b001, 32'h3000, 32'h0, -1, 0);
      issue(5'd17, 32'h0, 1'b1, 1'b1, 3'b110, 32'h3003, 32'hA5A5_5A5A, 0, 2);

      for (int i = 0; i < 300; i++) begin
         wt = int'($urandom_range(0, 7));
         if (wt == 7) wt = -1;
         xs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         issue(5'($urandom), $urandom, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
               3'($urandom), $urandom, $urandom, wt, xs);
      end

      // Abort a load in WAIT_LOAD with reset; its late done must not commit.
      @(negedge clk_i);
      w_rd_i       = 5'd20;
      w_rd_write_i = 1'b1;
      w_load_i     = 1'b1;
      w_fun_i      = 3'b010;
      dm_load_done_i = 1'b0;
      x_stall_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      #2;
      err_exp = 1'b0;
      rst_n_i = 1'b0;
      idle_inputs();
      #1;
      check("midrst_write", {31'h0, rf_rd_write_o}, 32'h0);
      check("midrst_rd", {27'h0, rf_rd_o}, 32'h0);
      check("midrst_value", rf_rd_value_o, 32'h0);
      check("midrst_err", {31'h0, w_load_error_o}, 32'h0);
      check("midrst_stall", {31'h0, w_stall_req_o}, 32'h0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'hFFFF_FFFF;
      @(negedge clk_i);
      dm_load_done_i = 1'b0;
      repeat (4) @(negedge clk_i);
      check("pending_writes", 32'(q_exp.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
